// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// mult_div_unit
//   Iterative WIDTH-bit multiply/divide unit (MULT/MULTU/DIV/DIVU).
//   Shift-add multiply and restoring divide, one bit per cycle, WIDTH cycles.
//   Produces HI/LO and a combinational stall for the single-cycle core.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_res_q;    // product or quotient must be negated
  logic             neg_rem_q;    // remainder takes dividend sign
  logic             b_zero_q;     // divide with zero divisor
  logic [WIDTH-1:0] opnd_q;       // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] a_raw_q;      // dividend as presented, returned on divide by zero
  logic [WIDTH-1:0] rem_q;        // mul: upper partial product; div: partial remainder
  logic [WIDTH-1:0] quo_q;        // mul: multiplier/lower product; div: dividend/quotient
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             ready_q;
  logic             dbz_q;

  // Accept decode and operand magnitudes for signed ops
  logic             accept;
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept    = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & operand_a[WIDTH-1];
  assign b_neg     = is_signed & operand_b[WIDTH-1];
  assign a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
  assign b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;

  // One multiply step: conditionally add multiplicand, then shift the pair right
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_rem_nx, mul_quo_nx;

  assign mul_sum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_rem_nx = mul_sum[WIDTH:1];
  assign mul_quo_nx = {mul_sum[0], quo_q[WIDTH-1:1]};

  // One restoring divide step; the shifted remainder is below 2*divisor so the
  // difference sign bit alone tells whether the trial subtraction succeeded
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

  assign div_shift  = {rem_q, quo_q[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, opnd_q};
  assign div_ge     = ~div_diff[WIDTH];
  assign div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_nx = {quo_q[WIDTH-2:0], div_ge};

  // Sign-corrected final results, taken from the last iteration's outputs
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {mul_rem_nx, mul_quo_nx};
  assign prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_res_q ? (~div_quo_nx + 1'b1) : div_quo_nx;
  assign rem_fix  = neg_rem_q ? (~div_rem_nx + 1'b1) : div_rem_nx;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == CNT_ONE) state_d = S_DONE;
      S_DONE:  state_d = start ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: hold the PC from the request cycle through the last BUSY cycle
  always_comb begin
    stall = (start & ((state_q == S_IDLE) | (state_q == S_DONE))) | (state_q == S_BUSY);
  end

  // Datapath: operand capture, iteration and result commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (accept) begin
        cnt_q     <= CNT_LOAD;
        is_div_q  <= op[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        b_zero_q  <= op[1] & (operand_b == '0);
        opnd_q    <= op[1] ? b_mag : a_mag;
        a_raw_q   <= operand_a;
        rem_q     <= '0;
        quo_q     <= op[1] ? a_mag : b_mag;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - CNT_ONE;
        rem_q <= is_div_q ? div_rem_nx : mul_rem_nx;
        quo_q <= is_div_q ? div_quo_nx : mul_quo_nx;
        if (cnt_q == CNT_ONE) begin
          ready_q <= 1'b1;
          dbz_q   <= b_zero_q;
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_zero_q) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
      end
    end
  end

  assign ready       = ready_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
